// File: rtl/sd_bch_frame_sequencer.sv
// sd_bch_frame_sequencer: drives BCH decoder counter controls per codeword; SD_BCH_SEQ_FLUSH_EN adds a drain phase
module sd_bch_frame_sequencer #(
  parameter int PARALLELISM = 4,
  parameter int CW_LEN      = 1020,
  parameter int GF_LEN      = 10,
  parameter int SETTLE_CYC  = 3,
  parameter int FLUSH_CYC   = 16
) (
  input  logic              clk,
  input  logic              Arst_n,
  input  logic              start,
  input  logic [7:0]        num_cw,
  input  logic              stall,
  input  logic              abort,
  output logic              ctr_Srst,
  output logic              ctr_en,
  output logic              ctr_init,
  output logic              ctr_stim_Srst,
  output logic [GF_LEN-1:0] out_clk_cnt,
  output logic [7:0]        cw_idx,
  output logic              busy,
  output logic              done
);
  localparam int OP_CLK_CYCLE = (CW_LEN + PARALLELISM - 1) / PARALLELISM;
  localparam logic [GF_LEN-1:0] LAST_BEAT = GF_LEN'(OP_CLK_CYCLE - 1);
  localparam int SW = $clog2(SETTLE_CYC + 1) + 1;
`ifdef SD_BCH_SEQ_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int DRAIN_CYC = FLUSH_EN ? FLUSH_CYC : 0;
  typedef enum logic [2:0] {
    IDLE, SRST, SETTLE, PRIME, RUN,
`ifdef SD_BCH_SEQ_FLUSH_EN
    FLUSH,
`endif
    DONE
  } state_t;
  state_t            state_q, state_d;
  logic [7:0]        ncw_q, ncw_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              srst_q, srst_d, en_q, en_d, init_q, init_d, stim_q, stim_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [GF_LEN-1:0] cnt_q, cnt_d;
  logic [7:0]        cw_q, cw_d;
  logic              wrap, go_prime, go_done;
`ifdef SD_BCH_SEQ_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYC + 1) + 1;
  logic [FW-1:0]     fcnt_q, fcnt_d;
`endif
  assign wrap          = cnt_q == LAST_BEAT;
  assign ctr_Srst      = srst_q;
  assign ctr_en        = en_q;
  assign ctr_init      = init_q;
  assign ctr_stim_Srst = stim_q;
  assign out_clk_cnt   = cnt_q;
  assign cw_idx        = cw_q;
  assign busy          = busy_q;
  assign done          = done_q;
  // next state and next registered outputs; the beat counter only moves on cycles that will carry ctr_en
  always_comb begin
    state_d  = state_q;
    ncw_d    = ncw_q;
    scnt_d   = '0;
    srst_d   = 1'b0;
    en_d     = 1'b0;
    init_d   = 1'b0;
    stim_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    cw_d     = cw_q;
    go_prime = 1'b0;
    go_done  = 1'b0;
`ifdef SD_BCH_SEQ_FLUSH_EN
    fcnt_d   = '0;
`endif
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      srst_d  = 1'b1;
      cnt_d   = '0;
      cw_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (start && OP_CLK_CYCLE != 0) begin
          ncw_d = num_cw;
          if (num_cw == 8'd0) go_done = 1'b1;
          else begin
            state_d = SRST;
            srst_d  = 1'b1;
            stim_d  = 1'b1;
          end
        end
        SRST: if (SETTLE_CYC == 0) go_prime = 1'b1; else state_d = SETTLE;
        SETTLE: begin
          scnt_d   = scnt_q + 1'b1;
          go_prime = scnt_q == SW'(SETTLE_CYC - 1);
        end
        PRIME, RUN: if (init_q && cw_q == ncw_q) begin
          go_done = DRAIN_CYC == 0;
`ifdef SD_BCH_SEQ_FLUSH_EN
          if (DRAIN_CYC != 0) begin
            state_d = FLUSH;
            en_d    = 1'b1;
          end
`endif
        end else begin
          state_d = RUN;
          en_d    = !stall;
          if (!stall) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            init_d = wrap;
            cw_d   = cw_q + {7'd0, wrap};
          end
        end
`ifdef SD_BCH_SEQ_FLUSH_EN
        FLUSH: begin
          fcnt_d  = fcnt_q + 1'b1;
          go_done = fcnt_q == FW'(DRAIN_CYC - 1);
          en_d    = !go_done;
        end
`endif
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (go_prime) begin
        state_d = PRIME;
        en_d    = 1'b1;
        init_d  = 1'b1;
        stim_d  = 1'b1;
        cnt_d   = '0;
        cw_d    = '0;
      end
      if (go_done) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
    busy_d = state_d != IDLE && state_d != DONE;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge Arst_n) begin
    if (!Arst_n) begin
      state_q <= IDLE;
      ncw_q   <= '0;
      scnt_q  <= '0;
      srst_q  <= 1'b0;
      en_q    <= 1'b0;
      init_q  <= 1'b0;
      stim_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      cw_q    <= '0;
`ifdef SD_BCH_SEQ_FLUSH_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ncw_q   <= ncw_d;
      scnt_q  <= scnt_d;
      srst_q  <= srst_d;
      en_q    <= en_d;
      init_q  <= init_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
`ifdef SD_BCH_SEQ_FLUSH_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end
endmodule
